mips_multicycle_core: RTL and testbench



---
 rtl/mips_multicycle_core.sv | 230 +++++++++++++++++++++++
 tb/tb_mips_multicycle_core.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/mips_multicycle_core.sv
// Multi-cycle MIPS core: shared ALU, 32x32 register file and one unified
// instruction/data memory port with a req/ready handshake (assumes ADDR_W <= 32).
module mips_multicycle_core #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              CLK,
    input  logic              Reset,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] pc,
    output logic              instr_done,
    output logic              illegal_instr
);
    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
        EXEC, ALUWB, ADDIEX, ADDIWB, BRANCH, JUMP
    } state_t;

    localparam logic [2:0] ALU_AND = 3'b000, ALU_OR  = 3'b001, ALU_ADD = 3'b010,
                           ALU_SUB = 3'b110, ALU_SLT = 3'b111;
    localparam logic [5:0] OP_R = 6'h00, OP_LW = 6'h23, OP_SW = 6'h2B,
                           OP_BEQ = 6'h04, OP_ADDI = 6'h08, OP_J = 6'h02;

    state_t      state;
    logic [31:0] ir, a, b, alu_out, mdr;
    logic [31:0] regs [32];

    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd;
    logic [31:0] imm, rs_val, rt_val;

    assign op     = ir[31:26];
    assign rs     = ir[25:21];
    assign rt     = ir[20:16];
    assign rd     = ir[15:11];
    assign funct  = ir[5:0];
    assign imm    = {{16{ir[15]}}, ir[15:0]};
    assign rs_val = regs[rs];
    assign rt_val = regs[rt];

    logic [2:0] funct_op;
    logic       funct_ok, legal;

    always_comb begin
        funct_op = ALU_ADD;
        funct_ok = 1'b1;
        case (funct)
            6'h20:   funct_op = ALU_ADD;
            6'h22:   funct_op = ALU_SUB;
            6'h24:   funct_op = ALU_AND;
            6'h25:   funct_op = ALU_OR;
            6'h2A:   funct_op = ALU_SLT;
            default: funct_ok = 1'b0;
        endcase
        case (op)
            OP_R:                                 legal = funct_ok;
            OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J:  legal = 1'b1;
            default:                              legal = 1'b0;
        endcase
    end

    // Single ALU: operands steered by state (PC+4, branch target, address, execute, compare)
    logic [31:0] alu_x, alu_z, alu_y;
    logic [2:0]  alu_op;

    always_comb begin
        alu_x  = 32'(pc);
        alu_z  = 32'd4;
        alu_op = ALU_ADD;
        case (state)
            DECODE:         alu_z = {imm[29:0], 2'b00};
            MEMADR, ADDIEX: begin alu_x = a; alu_z = imm; end
            EXEC:           begin alu_x = a; alu_z = b; alu_op = funct_op; end
            BRANCH:         begin alu_x = a; alu_z = b; alu_op = ALU_SUB; end
            default:        ;
        endcase
        alu_y = alu_x + alu_z;
        case (alu_op)
            ALU_AND: alu_y = alu_x & alu_z;
            ALU_OR:  alu_y = alu_x | alu_z;
            ALU_SUB: alu_y = alu_x - alu_z;
            ALU_SLT: alu_y = {31'd0, $signed(alu_x) < $signed(alu_z)};
            default: alu_y = alu_x + alu_z;
        endcase
    end

    logic [31:0]       pc_ext, jump_full;
    logic [ADDR_W-1:0] jump_target, branch_target;

    assign pc_ext        = 32'(pc);
    assign jump_full     = {pc_ext[31:28], ir[25:0], 2'b00};
    assign jump_target   = jump_full[ADDR_W-1:0];
    assign branch_target = (alu_y == 32'd0) ? alu_out[ADDR_W-1:0] : pc;

    // Every transition back to FETCH issues the next fetch request on the same edge,
    // so only the first fetch after reset spends a cycle raising mem_req.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state         <= FETCH;
            pc            <= RESET_PC;
            ir            <= '0;
            a             <= '0;
            b             <= '0;
            alu_out       <= '0;
            mdr           <= '0;
            mem_req       <= 1'b0;
            mem_we        <= 1'b0;
            mem_addr      <= RESET_PC;
            mem_wdata     <= '0;
            instr_done    <= 1'b0;
            illegal_instr <= 1'b0;
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else begin
            instr_done    <= 1'b0;
            illegal_instr <= 1'b0;
            case (state)
                FETCH: begin
                    if (!mem_req) begin
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= pc;
                    end else if (mem_ready) begin
                        ir      <= mem_rdata;
                        pc      <= alu_y[ADDR_W-1:0];
                        mem_req <= 1'b0;
                        state   <= DECODE;
                    end
                end
                DECODE: begin
                    a       <= rs_val;
                    b       <= rt_val;
                    alu_out <= alu_y;
                    if (!legal) begin
                        illegal_instr <= 1'b1;
                        mem_req       <= 1'b1;
                        mem_addr      <= pc;
                        state         <= FETCH;
                    end else begin
                        case (op)
                            OP_LW, OP_SW: state <= MEMADR;
                            OP_R:         state <= EXEC;
                            OP_BEQ:       state <= BRANCH;
                            OP_ADDI:      state <= ADDIEX;
                            default:      state <= JUMP;
                        endcase
                    end
                end
                MEMADR: begin
                    alu_out  <= alu_y;
                    mem_req  <= 1'b1;
                    mem_addr <= alu_y[ADDR_W-1:0];
                    mem_we   <= (op == OP_SW);
                    if (op == OP_SW) begin
                        mem_wdata <= b;
                        state     <= MEMWR;
                    end else begin
                        state <= MEMRD;
                    end
                end
                MEMRD: begin
                    if (mem_ready) begin
                        mdr     <= mem_rdata;
                        mem_req <= 1'b0;
                        state   <= MEMWB;
                    end
                end
                MEMWB: begin
                    if (rt != 5'd0) regs[rt] <= mdr;
                    instr_done <= 1'b1;
                    mem_req    <= 1'b1;
                    mem_addr   <= pc;
                    state      <= FETCH;
                end
                MEMWR: begin
                    if (mem_ready) begin
                        instr_done <= 1'b1;
                        mem_we     <= 1'b0;
                        mem_addr   <= pc;
                        state      <= FETCH;
                    end
                end
                EXEC: begin
                    alu_out <= alu_y;
                    state   <= ALUWB;
                end
                ALUWB: begin
                    if (rd != 5'd0) regs[rd] <= alu_out;
                    instr_done <= 1'b1;
                    mem_req    <= 1'b1;
                    mem_addr   <= pc;
                    state      <= FETCH;
                end
                ADDIEX: begin
                    alu_out <= alu_y;
                    state   <= ADDIWB;
                end
                ADDIWB: begin
                    if (rt != 5'd0) regs[rt] <= alu_out;
                    instr_done <= 1'b1;
                    mem_req    <= 1'b1;
                    mem_addr   <= pc;
                    state      <= FETCH;
                end
                BRANCH: begin
                    pc         <= branch_target;
                    instr_done <= 1'b1;
                    mem_req    <= 1'b1;
                    mem_addr   <= branch_target;
                    state      <= FETCH;
                end
                JUMP: begin
                    pc         <= jump_target;
                    instr_done <= 1'b1;
                    mem_req    <= 1'b1;
                    mem_addr   <= jump_target;
                    state      <= FETCH;
                end
                default: begin
                    mem_req <= 1'b0;
                    state   <= FETCH;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mips_multicycle_core.sv
// Directed bench for mips_multicycle_core: small program run against a
// unified memory model with a programmable number of wait cycles per request.
module tb_mips_multicycle_core;
    logic        CLK = 1'b0;
    logic        Reset = 1'b1;
    logic        mem_req, mem_we, mem_ready, instr_done, illegal_instr;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, pc;

    int checks = 0, errors = 0, cyc = 0;
    int wait_cfg = 0, wait_cnt = 0;
    int base, at, nwr;
    logic found;

    logic [31:0] imem [256];
    logic [31:0] dmem [4];
    logic        dsel;

    always #5 CLK = ~CLK;

    mips_multicycle_core #(.ADDR_W(32), .RESET_PC(32'h100)) dut (
        .CLK(CLK), .Reset(Reset),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .pc(pc), .instr_done(instr_done), .illegal_instr(illegal_instr)
    );

    // Addresses below 0x10 are data; everything else is instruction memory
    assign dsel      = mem_addr < 32'h10;
    assign mem_rdata = dsel ? dmem[mem_addr[3:2]] : imem[mem_addr[9:2]];
    assign mem_ready = mem_req && (wait_cnt >= wait_cfg);

    always @(posedge CLK) begin
        cyc <= cyc + 1;
        if (!mem_req || mem_ready) wait_cnt <= 0;
        else                       wait_cnt <= wait_cnt + 1;
        if (mem_req && mem_ready && mem_we && dsel) dmem[mem_addr[3:2]] <= mem_wdata;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_pulse(input string tag, input bit ill, output int t);
        t = -1;
        for (int n = 0; n < 60 && t < 0; n++) begin
            @(posedge CLK); #1;
            if ((ill ? illegal_instr : instr_done) === 1'b1) t = cyc;
        end
        if (t < 0) begin
            checks++;
            errors++;
            $error("FAIL %s: got no pulse expected pulse within 60 cycles", tag);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) imem[i] = 32'h0;
        imem[64] = 32'h20010005;  // addi $1,$0,5
        imem[65] = 32'h2002FFFD;  // addi $2,$0,-3
        imem[66] = 32'h00221820;  // add  $3,$1,$2
        imem[67] = 32'h0041202A;  // slt  $4,$2,$1
        imem[68] = 32'hAC030008;  // sw   $3,8($0)
        imem[69] = 32'h8C050008;  // lw   $5,8($0)
        imem[70] = 32'h20000007;  // addi $0,$0,7
        imem[71] = 32'hFC000000;  // opcode 0x3F
        imem[72] = 32'h08000004;  // j 0x4 -> 0x10
        imem[4]  = 32'h1021FFFF;  // beq $1,$1,-1
        imem[5]  = 32'h08000008;  // j 0x8 -> 0x20
        imem[8]  = 32'h08000040;  // j 0x40 -> 0x100

        Reset = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        check("rst_pc", pc, 32'h100);
        check("rst_req", {31'd0, mem_req}, 32'd0);
        check("rst_addr", mem_addr, 32'h100);
        check("rst_done", {31'd0, instr_done}, 32'd0);

        Reset = 1'b0;
        @(posedge CLK); #1;
        base = cyc;
        check("fetch0_req", {31'd0, mem_req}, 32'd1);
        check("fetch0_addr", mem_addr, 32'h100);
        check("fetch0_we", {31'd0, mem_we}, 32'd0);

        wait_pulse("addi1", 0, at);
        check("addi1_cyc", 32'(at - base), 32'd4);
        check("r1", dut.regs[1], 32'd5);
        wait_pulse("addi2", 0, at);
        check("addi2_cyc", 32'(at - base), 32'd8);
        check("r2", dut.regs[2], 32'hFFFF_FFFD);
        wait_pulse("add", 0, at);
        check("add_cyc", 32'(at - base), 32'd12);
        check("r3", dut.regs[3], 32'd2);
        wait_pulse("slt", 0, at);
        check("slt_cyc", 32'(at - base), 32'd16);
        check("r4", dut.regs[4], 32'd1);
        check("slt_pc", pc, 32'h110);

        // sw with 3 wait cycles on every request; write must stay stable
        wait_cfg = 3;
        nwr = 0;
        at = -1;
        for (int n = 0; n < 60 && at < 0; n++) begin
            @(posedge CLK); #1;
            if (mem_req && mem_we) begin
                nwr++;
                check("sw_addr", mem_addr, 32'h8);
                check("sw_data", mem_wdata, 32'd2);
            end
            if (instr_done) at = cyc;
        end
        check("sw_cyc", 32'(at - base), 32'd26);
        check("sw_hold_cycles", 32'(nwr), 32'd4);

        wait_pulse("lw", 0, at);
        check("lw_cyc", 32'(at - base), 32'd37);
        check("r5", dut.regs[5], 32'd2);
        wait_cfg = 0;

        wait_pulse("addi_r0", 0, at);
        check("addi_r0_cyc", 32'(at - base), 32'd41);
        check("r0", dut.regs[0], 32'd0);

        wait_pulse("illegal", 1, at);
        check("ill_cyc", 32'(at - base), 32'd43);
        check("ill_pc", pc, 32'h120);
        check("ill_done", {31'd0, instr_done}, 32'd0);
        check("ill_r3", dut.regs[3], 32'd2);

        wait_pulse("j_0x10", 0, at);
        check("j10_cyc", 32'(at - base), 32'd46);
        check("j10_pc", pc, 32'h10);

        wait_pulse("beq_taken", 0, at);
        check("beqt_cyc", 32'(at - base), 32'd49);
        check("beqt_pc", pc, 32'h10);
        imem[4] = 32'h10220003;   // beq $1,$2,+3 (not taken)

        wait_pulse("beq_not", 0, at);
        check("beqn_cyc", 32'(at - base), 32'd52);
        check("beqn_pc", pc, 32'h14);

        wait_pulse("j_0x20", 0, at);
        check("j20_pc", pc, 32'h20);
        imem[64] = 32'h8C060008;  // lw $6,8($0)

        wait_pulse("j_0x100", 0, at);
        check("j100_cyc", 32'(at - base), 32'd58);
        check("j100_pc", pc, 32'h100);

        // Reset in the middle of a waited data read
        wait_cfg = 3;
        found = 1'b0;
        for (int n = 0; n < 40 && !found; n++) begin
            @(posedge CLK); #1;
            if (mem_req && !mem_we && mem_addr == 32'h8) found = 1'b1;
        end
        check("rd_req_seen", {31'd0, found}, 32'd1);
        @(posedge CLK); #1;
        check("rd_waiting", {31'd0, mem_req & ~mem_ready}, 32'd1);
        Reset = 1'b1;
        @(posedge CLK); #1;
        check("mid_rst_req", {31'd0, mem_req}, 32'd0);
        check("mid_rst_pc", pc, 32'h100);
        check("mid_rst_addr", mem_addr, 32'h100);
        check("mid_rst_r1", dut.regs[1], 32'd0);
        check("mid_rst_r6", dut.regs[6], 32'd0);
        Reset = 1'b0;
        wait_cfg = 0;
        @(posedge CLK); #1;
        check("post_rst_req", {31'd0, mem_req}, 32'd1);
        check("post_rst_addr", mem_addr, 32'h100);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
